// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite I2S transmitter: TX FIFO fed over AHB, SCK/WS generated locally,
// samples shifted out MSB first in standard I2S framing, FIFO-low IRQ.
// Optional build macro I2S_TX_MONO_EN implements CTRL[3] MONO (one word per frame,
// repeated in both slots); without it CTRL[3] reads 0 and every slot pops.
module ahbl_i2s_tx #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int DIV_RST = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        SCK,
  output logic        WS,
  output logic        SD,
  output logic        IRQ
);

  localparam int BW    = $clog2(2 * DW);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t state_q, state_d;

  logic [7:0]    haddr_d;
  logic          htrans_d, hwrite_d, hsel_d;
  logic          wr_en, rd_en;
  logic          wr_ctrl, wr_txdata, wr_clkdiv, wr_thresh, wr_clear;

  logic          en, irq_en, mono_on;
  logic [7:0]    clkdiv;
  logic [AW:0]   thresh;
  logic          unf, ovf;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr, level;
  logic          empty, full, flush, push, pop, pop_point;
  logic [DW-1:0] head, word;

  logic [7:0]    div_cnt, div_act;
  logic [BW-1:0] b, b_nx;
  logic [DW-1:0] shreg;
  logic          sck_tick, fall, active, load_l, load_r;
  logic [31:0]   status;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:8], HTRANS[0], HSIZE};

  assign HREADYOUT = 1'b1;

  // AHB address phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_d  <= '0;
      htrans_d <= 1'b0;
      hwrite_d <= 1'b0;
      hsel_d   <= 1'b0;
    end else if (HREADY) begin
      haddr_d  <= HADDR[7:0];
      htrans_d <= HTRANS[1];
      hwrite_d <= HWRITE;
      hsel_d   <= HSEL;
    end
  end

  assign wr_en     = htrans_d & hsel_d & hwrite_d;
  assign rd_en     = htrans_d & hsel_d & ~hwrite_d;
  assign wr_ctrl   = wr_en && (haddr_d == 8'h00);
  assign wr_txdata = wr_en && (haddr_d == 8'h08);
  assign wr_clkdiv = wr_en && (haddr_d == 8'h0C);
  assign wr_thresh = wr_en && (haddr_d == 8'h10);
  assign wr_clear  = wr_en && (haddr_d == 8'h14);

  assign flush = wr_ctrl & HWDATA[2];

  // Control registers and sticky error flags
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
      clkdiv <= 8'(DIV_RST);
      thresh <= (AW+1)'(2 ** (AW - 1));
      unf    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= HWDATA[0];
        irq_en <= HWDATA[1];
      end
      if (wr_clkdiv) clkdiv <= HWDATA[7:0];
      if (wr_thresh) thresh <= HWDATA[AW:0];
      if (pop_point && empty)          unf <= 1'b1;
      else if (wr_clear && HWDATA[0])  unf <= 1'b0;
      if (wr_txdata && full)           ovf <= 1'b1;
      else if (wr_clear && HWDATA[1])  ovf <= 1'b0;
    end
  end

`ifdef I2S_TX_MONO_EN
  logic          mono;
  logic [DW-1:0] hold;

  // MONO control bit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     mono <= 1'b0;
    else if (wr_ctrl) mono <= HWDATA[3];
  end

  // Left-slot word kept for repetition in the right slot
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                hold <= '0;
    else if (active && load_l)   hold <= word;
  end

  assign mono_on = mono;
`else
  assign mono_on = 1'b0;
`endif

  // FIFO storage (no reset needed; validity tracked by pointers)
  always_ff @(posedge HCLK) begin
    if (push) mem[wptr[AW-1:0]] <= HWDATA[DW-1:0];
  end

  assign level = wptr - rptr;
  assign empty = (level == '0);
  assign full  = level[AW];
  assign head  = mem[rptr[AW-1:0]];
  assign push  = wr_txdata & ~full & ~flush;
  assign pop   = pop_point & ~empty;

  // FIFO pointers; flush wins over concurrent push/pop
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  assign sck_tick  = (div_cnt == div_act);
  assign fall      = sck_tick & SCK;
  assign b_nx      = (b == BW'(2 * DW - 1)) ? '0 : b + 1'b1;
  assign load_l    = fall && (b_nx == BW'(1));
  assign load_r    = fall && (b_nx == BW'(DW + 1));
  assign active    = (state_q != S_IDLE) && (state_d != S_IDLE);
  assign pop_point = active & (load_l | (load_r & ~mono_on));

  // Word entering the shift register at a slot start
  always_comb begin
    word = empty ? '0 : head;
`ifdef I2S_TX_MONO_EN
    if (load_r && mono) word = hold;
`endif
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a stop completes once the frame's trailing LSB period ends
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en) state_d = S_RUN;
      S_RUN:  if (!en) state_d = S_STOP;
      S_STOP: begin
        if (en)                        state_d = S_RUN;
        else if (fall && (b == '0))    state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit clock divider, frame counter and serialiser
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt <= '0;
      div_act <= 8'(DIV_RST);
      b       <= '0;
      shreg   <= '0;
      SCK     <= 1'b0;
      WS      <= 1'b0;
      SD      <= 1'b0;
    end else if (!active) begin
      div_cnt <= '0;
      div_act <= clkdiv;
      b       <= '0;
      shreg   <= '0;
      SCK     <= 1'b0;
      WS      <= 1'b0;
      SD      <= 1'b0;
    end else begin
      if (sck_tick) begin
        div_cnt <= '0;
        div_act <= clkdiv;
        SCK     <= ~SCK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        b  <= b_nx;
        WS <= (b_nx >= BW'(DW));
        if (load_l || load_r) begin
          shreg <= word;
          SD    <= word[DW-1];
        end else begin
          shreg <= shreg << 1;
          SD    <= shreg[DW-2];
        end
      end
    end
  end

  // FIFO-low interrupt, registered
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) IRQ <= 1'b0;
    else          IRQ <= irq_en & (level <= thresh);
  end

  // STATUS word assembly
  always_comb begin
    status           = '0;
    status[0]        = empty;
    status[1]        = full;
    status[2]        = unf;
    status[3]        = ovf;
    status[8 +: AW+1] = level;
  end

  // Read data mux from the registered address
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (haddr_d)
        8'h00:   HRDATA = {28'd0, mono_on, 1'b0, irq_en, en};
        8'h04:   HRDATA = status;
        8'h08:   HRDATA = '0;
        8'h0C:   HRDATA = {24'd0, clkdiv};
        8'h10:   HRDATA = 32'(thresh);
        8'h14:   HRDATA = '0;
        default: HRDATA = 32'hBADDBEEF;
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_i2s_tx.sv
// Self-checking bench for ahbl_i2s_tx: slot-level I2S reference model fed by
// the same pushes as the DUT, receiver capturing SD/WS at SCK rising edges.
module tb_ahbl_i2s_tx;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        SCK, WS, SD, IRQ;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  ahbl_i2s_tx #(.DW(32), .AW(4), .DIV_RST(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HSEL(HSEL),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .SCK(SCK), .WS(WS), .SD(SD), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  // receiver: one sample of WS/SD per SCK rising edge
  bit          rx_ws[$];
  bit          rx_sd[$];
  int unsigned rx_cyc[$];
  int unsigned cyc = 0;
  logic        sck_prev = 1'b0;

  always @(negedge HCLK) begin
    cyc++;
    if (SCK === 1'b1 && sck_prev === 1'b0) begin
      rx_ws.push_back(WS);
      rx_sd.push_back(SD);
      rx_cyc.push_back(cyc);
    end
    sck_prev = SCK;
  end

  // reference model: FIFO contents and sticky flags
  logic [31:0] mq[$];
  bit          m_unf = 1'b0;
  bit          m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    int unsigned lvl = mq.size();
    return (32'(lvl) << 8) | 32'(lvl == 0) | (32'(lvl == 16) << 1) |
           (32'(m_unf) << 2) | (32'(m_ovf) << 3);
  endfunction

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = {24'd0, a}; HTRANS = 2'b10; HWRITE = 1'b1;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = {24'd0, a}; HTRANS = 2'b10; HWRITE = 1'b0;
    @(negedge HCLK);
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic push_word(input logic [31:0] w);
    ahb_write(8'h08, w);
    if (mq.size() < 16) mq.push_back(w);
    else                m_ovf = 1'b1;
  endtask

  task automatic wait_edges(input int unsigned n, input int unsigned budget);
    int unsigned t = 0;
    while (rx_sd.size() < n && t < budget) begin
      @(negedge HCLK);
      t++;
    end
    if (rx_sd.size() < n) chk("edge_timeout", rx_sd.size(), n);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    chk(tag, d, exp);
  endtask

  // run nfull complete frames, stop at b=40 of the next one, check the stream
  task automatic run_check(input string tag, input int unsigned div,
                           input int unsigned nfull, input bit mono);
    int unsigned per = 2 * (div + 1);
    int unsigned n_exp = 64 * (nfull + 1) + 1;
    int unsigned werr = 0, perr = 0;
    logic [31:0] gl, gr, el, er;
    rx_ws.delete(); rx_sd.delete(); rx_cyc.delete();
    ahb_write(8'h0C, div);
    ahb_write(8'h00, mono ? 32'h9 : 32'h1);
    wait_edges(64 * nfull + 41, per * 64 * (nfull + 2));
    ahb_write(8'h00, 32'h0);
    repeat (per * 40) @(negedge HCLK);
    chk($sformatf("%s_edges", tag), rx_sd.size(), n_exp);
    chk($sformatf("%s_idle", tag), {29'd0, SCK, WS, SD}, 32'd0);
    if (rx_sd.size() == n_exp) begin
      for (int k = 0; k < n_exp; k++)
        if (rx_ws[k] != ((k % 64) >= 32)) werr++;
      for (int k = 1; k < n_exp; k++)
        if (rx_cyc[k] - rx_cyc[k-1] != per) perr++;
      chk($sformatf("%s_ws", tag), werr, 0);
      chk($sformatf("%s_period", tag), perr, 0);
      chk($sformatf("%s_sd_b0", tag), rx_sd[0], 0);
      for (int f = 0; f <= int'(nfull); f++) begin
        gl = '0; gr = '0;
        for (int i = 1; i <= 32; i++)  gl = {gl[30:0], rx_sd[64*f + i]};
        for (int i = 33; i <= 64; i++) gr = {gr[30:0], rx_sd[64*f + i]};
        if (mq.size() > 0) el = mq.pop_front();
        else begin el = '0; m_unf = 1'b1; end
        if (mono)              er = el;
        else if (mq.size() > 0) er = mq.pop_front();
        else begin er = '0; m_unf = 1'b1; end
        chk($sformatf("%s_f%0d_left", tag, f), gl, el);
        chk($sformatf("%s_f%0d_right", tag, f), gr, er);
      end
    end
    rd_chk($sformatf("%s_status", tag), 8'h04, status_exp());
    ahb_write(8'h14, 32'h1);
    m_unf = 1'b0;
    rd_chk($sformatf("%s_clr_unf", tag), 8'h04, status_exp());
    ahb_write(8'h14, 32'h2);
    m_ovf = 1'b0;
    rd_chk($sformatf("%s_clr_ovf", tag), 8'h04, status_exp());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HWDATA = '0; HREADY = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("rst_sck", SCK, 0);
    chk("rst_ws", WS, 0);
    chk("rst_sd", SD, 0);
    chk("rst_irq", IRQ, 0);
    HRESETn = 1'b1;
    rd_chk("rst_ctrl", 8'h00, 32'h0);
    rd_chk("rst_status", 8'h04, 32'h1);
    rd_chk("rst_clkdiv", 8'h0C, 32'd3);
    rd_chk("rst_thresh", 8'h10, 32'd8);
    rd_chk("rst_unmapped", 8'h20, 32'hBADDBEEF);
    chk("hreadyout", HREADYOUT, 1);

    // two known words, then an underflowing frame that ends with the stop
    ahb_write(8'h0C, 32'd1);
    rd_chk("clkdiv_rw", 8'h0C, 32'd1);
    push_word(32'hA5A5_0001);
    push_word(32'h8000_00FF);
    run_check("basic", 1, 1, 1'b0);

    // overflow: 17 random words, only 16 kept
    for (int i = 0; i < 17; i++) push_word($urandom);
    rd_chk("ovf_status", 8'h04, status_exp());
    run_check("fill", $urandom_range(0, 3), 8, 1'b0);

    // FIFO-low interrupt
    for (int i = 0; i < 4; i++) push_word($urandom);
    ahb_write(8'h10, 32'd2);
    rd_chk("thresh_rw", 8'h10, 32'd2);
    rx_ws.delete(); rx_sd.delete(); rx_cyc.delete();
    ahb_write(8'h0C, 32'd1);
    ahb_write(8'h00, 32'h3);
    repeat (2) @(negedge HCLK);
    chk("irq_lvl4", IRQ, 0);
    wait_edges(33, 400);
    chk("irq_lvl3", IRQ, 0);
    wait_edges(34, 400);
    chk("irq_lvl2", IRQ, 1);
    void'(mq.pop_front());
    void'(mq.pop_front());
    for (int i = 0; i < 3; i++) push_word($urandom);
    repeat (2) @(negedge HCLK);
    chk("irq_refill", IRQ, 0);
    ahb_write(8'h00, 32'h2);
    repeat (400) @(negedge HCLK);
    rd_chk("irq_status", 8'h04, status_exp());
    ahb_write(8'h00, 32'h4);
    mq.delete();
    rd_chk("flush_status", 8'h04, status_exp());
    rd_chk("flush_ctrl", 8'h00, 32'h0);
    chk("irq_off", IRQ, 0);

`ifdef I2S_TX_MONO_EN
    push_word(32'h1234_5678);
    push_word($urandom);
    run_check("mono", 1, 0, 1'b1);
    ahb_write(8'h00, 32'h4);
    mq.delete();
`else
    ahb_write(8'h00, 32'h8);
    rd_chk("mono_absent", 8'h00, 32'h0);
    ahb_write(8'h00, 32'h0);
`endif

    // asynchronous reset in the middle of a frame
    push_word(32'hFFFF_FFFF);
    ahb_write(8'h10, 32'd16);
    rx_ws.delete(); rx_sd.delete(); rx_cyc.delete();
    ahb_write(8'h00, 32'h3);
    wait_edges(6, 400);
    chk("pre_rst_sck", SCK, 1);
    chk("pre_rst_sd", SD, 1);
    chk("pre_rst_irq", IRQ, 1);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_out", {28'd0, SCK, WS, SD, IRQ}, 32'd0);
    mq.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd_chk("post_rst_status", 8'h04, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_i2s_tx.md
Name: ahbl_i2s_tx

Overview:
- AHB-Lite peripheral that transmits audio samples as an I2S bus master; the transmit counterpart of the I2S receiver peripheral.
- Software or the DMAC pushes 32-bit words into an internal TX FIFO.
- The block generates SCK and WS itself and shifts the words out on SD, MSB first, in standard I2S format.
- A level interrupt requests a refill when the FIFO drains to a programmable threshold.

Parameters:
- DW, 32: sample/slot width in bits; SCK periods per channel slot.
- AW, 4: FIFO address width; depth = 2^AW words.
- DIV_RST, 3: reset value of CLKDIV.

Ports:
- HCLK  in  1  clock; all logic in this domain.
- HRESETn  in  1  reset; asynchronous, active-low.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  AHB write.
- HSIZE  in  3  AHB size; ignored, word access only.
- HWDATA  in  32  AHB write data.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied 1, zero wait states.
- SCK  out  1  I2S bit clock.
- WS  out  1  word select; 0 = left slot, 1 = right slot.
- SD  out  1  serial data.
- IRQ  out  1  FIFO-low interrupt, level.

Behaviour:
- AHB: address phase (HADDR, HTRANS, HWRITE, HSEL) is registered when HREADY=1.
- Write enable = HTRANS_d[1] & HSEL_d & HWRITE_d; read enable is the same with !HWRITE_d.
- Decode on HADDR_d[7:0]; HRDATA is combinational from the registered address. Unmapped reads return 32'hBADDBEEF.
- 0x00 CTRL (rw, reset 0): [0] EN, [1] IRQ_EN, [2] FLUSH (write 1 empties FIFO, reads 0), [3] MONO (see Optional Feature).
- 0x04 STATUS (ro): [0] empty, [1] full, [2] UNDERFLOW sticky, [3] OVERFLOW sticky, [8+:AW+1] level.
- 0x08 TXDATA (wo, reads 0): write pushes HWDATA into the FIFO.
  - Push when full: data dropped, OVERFLOW set.
- 0x0C CLKDIV (rw, [7:0], reset DIV_RST).
- 0x10 THRESH (rw, [AW:0], reset 2^(AW-1)).
- 0x14 CLEAR (wo): [0] clears UNDERFLOW, [1] clears OVERFLOW.
- Clock generation: half-period counter counts 0..CLKDIV and toggles SCK on reaching CLKDIV, so SCK period = 2*(CLKDIV+1) HCLK cycles.
- WS and SD change only on the HCLK edge that drives SCK 1->0.
- Frame structure: bit counter b runs 0..2*DW-1 and advances on each SCK falling edge. WS = (b >= DW).
- SD lags WS by one SCK period (standard I2S): at b=0 and b=DW, SD carries the LSB of the previous slot.
- Word loading: at the falling edge that makes b=1 (left) or b=DW+1 (right), one word is popped into the shift register and its MSB is driven on SD.
  - FIFO words alternate left, right.
- Underflow: FIFO empty at a pop point loads 0, sets UNDERFLOW, and does not pop.
- Simultaneous push and pop: both occur; level unchanged. FLUSH concurrent with push: flush wins.
- State machine:
  - IDLE: SCK=0, WS=0, SD=0, counters 0.
  - IDLE -> RUN on EN=1.
  - RUN -> STOPPING on EN=0.
  - STOPPING finishes the current frame (b wraps to 0), then -> IDLE.
  - FLUSH while running empties the FIFO; the word already in the shift register completes.
- CLKDIV write while running takes effect at the next counter wrap.
- IRQ = IRQ_EN & (level <= THRESH), registered, one cycle latency.
- Reset (any time): all registers and outputs clear asynchronously; SCK, WS, SD, IRQ = 0; FIFO empty.

Optional Feature:
- Macro: I2S_TX_MONO_EN.
- Defined: CTRL[3] MONO is implemented. With MONO=1, each popped word is sent in both the left and right slot, with one pop per frame at b=1 only. Underflow is checked at that pop.
- Undefined: CTRL[3] reads 0, writes are ignored, and every slot pops.

Test Plan:
- Reset, then read all registers -> CTRL=0, STATUS=0x0000_0001, CLKDIV=3, THRESH=8, unmapped 0x20 = 0xBADDBEEF; SCK, WS, SD, IRQ = 0.
- CLKDIV=1; push 0xA5A5_0001 and 0x8000_00FF; EN=1 -> SCK period 4 HCLK; WS low for 32 SCK then high for 32.
  - SD at b=1..32 = 0xA5A5_0001 MSB first; SD at b=33..64 = 0x8000_00FF.
  - Receiver model captures both words.
- EN=1 with FIFO empty -> SD=0 for the whole frame, UNDERFLOW=1; CLEAR bit0 -> UNDERFLOW=0.
- Push 17 words with AW=4 -> full=1, level=16, OVERFLOW=1, 17th word never transmitted.
- IRQ_EN=1, THRESH=2, 4 words queued and running -> IRQ rises one cycle after level reaches 2.
  - Push 3 words -> IRQ falls.
- EN=0 at b=40 -> transmission continues to frame end, then SCK idles at 0.
- Assert HRESETn low mid-frame -> outputs 0 without waiting for an HCLK edge.
- With I2S_TX_MONO_EN, MONO=1, push 0x1234_5678 -> the same word is sent on both WS phases and level drops by 1.
